// File: rtl/rambus_pkg.sv
// rambus_pkg: shared types and constants for the rambus SRAM self-test initiator.
//   bist_state_t     - BIST controller state encoding
//   PAT_*            - pattern mode select values for mode_i
//   RAMBUS_SEL_BYTE0 - byte-lane select driven on every transfer (only byte 0 is tested)
package rambus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WR_GAP,
      ST_RD,
      ST_RD_GAP,
      ST_DONE,
      ST_ABORT
   } bist_state_t;

   localparam logic [1:0] PAT_ADDR    = 2'd0;
   localparam logic [1:0] PAT_NADDR   = 2'd1;
   localparam logic [1:0] PAT_CHECKER = 2'd2;
   localparam logic [1:0] PAT_CONST   = 2'd3;

   localparam logic [3:0] RAMBUS_SEL_BYTE0 = 4'b0001;

endpackage

// File: rtl/rambus_bist_pattern.sv
// rambus_bist_pattern: combinational test pattern p(a) for one word address.
//   i_mode - pattern mode (PAT_*)
//   i_seed - pattern seed
//   i_addr - low byte of the word address
//   o_pat  - expected byte 0 contents for that address
module rambus_bist_pattern
   import rambus_pkg::*;
(
   input  logic [1:0] i_mode,
   input  logic [7:0] i_seed,
   input  logic [7:0] i_addr,
   output logic [7:0] o_pat
);

   always_comb begin
      o_pat = i_seed;
      case (i_mode)
         PAT_ADDR:    o_pat = i_addr ^ i_seed;
         PAT_NADDR:   o_pat = ~(i_addr ^ i_seed);
         PAT_CHECKER: o_pat = i_addr[0] ? 8'hAA : 8'h55;
         PAT_CONST:   o_pat = i_seed;
         default:     o_pat = i_seed;
      endcase
   end

endmodule

// File: rtl/rambus_bist.sv
// rambus_bist: Wishbone classic initiator that writes a pattern to every word
// of the rambus SRAM, reads it back and reports the result.
//   rambus_wb_clk_i / rambus_wb_rst_i - clock, synchronous active-high reset
//   start_i, mode_i, seed_i           - one-cycle start, pattern mode and seed
//   rambus_wb_*_o / rambus_wb_*_i     - Wishbone initiator port to rambus
//   busy_o, done_o                    - run in progress, completion/abort pulse
//   pass_o, timeout_o                 - held result flags after done
//   err_count_o, first_err_addr_o     - mismatch count, first failing address
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start_i
// ST_WR     | write request on the bus, waiting for ack
// ST_WR_GAP | one idle bus cycle after a write
// ST_RD     | read request on the bus, waiting for ack, compare on ack
// ST_RD_GAP | one idle bus cycle after a read
// ST_DONE   | done_o pulse, pass_o valid
// ST_ABORT  | ack timeout, done_o pulse with timeout_o set
module rambus_bist
   import rambus_pkg::*;
#(
   parameter int DEPTH   = 512,
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 255
) (
   input  logic              rambus_wb_clk_i,
   input  logic              rambus_wb_rst_i,
   input  logic              start_i,
   input  logic [1:0]        mode_i,
   input  logic [7:0]        seed_i,
   output logic              rambus_wb_cyc_o,
   output logic              rambus_wb_stb_o,
   output logic              rambus_wb_we_o,
   output logic [3:0]        rambus_wb_sel_o,
   output logic [ADDR_W-1:0] rambus_wb_addr_o,
   output logic [31:0]       rambus_wb_dat_o,
   input  logic              rambus_wb_ack_i,
   input  logic [31:0]       rambus_wb_dat_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic              timeout_o,
   output logic [ADDR_W:0]   err_count_o,
   output logic [ADDR_W-1:0] first_err_addr_o
);

   localparam int                TMO_W     = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

   bist_state_t       r_state;
   logic              r_cyc, r_stb, r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_dat;
   logic [1:0]        r_mode;
   logic [7:0]        r_seed;
   logic              r_last;
   logic [TMO_W-1:0]  r_tmo;
   logic              r_busy, r_done, r_pass, r_timeout;
   logic [ADDR_W:0]   r_err_count;
   logic [ADDR_W-1:0] r_first_err;

   logic [1:0]        w_pat_mode;
   logic [7:0]        w_pat_seed;
   logic [7:0]        w_pat_addr;
   logic [7:0]        w_pat;
   logic              w_unused_dat;

   // In IDLE the pattern must already reflect the incoming mode/seed so the
   // first write data can be registered on the start edge.
   assign w_pat_mode   = (r_state == ST_IDLE) ? mode_i : r_mode;
   assign w_pat_seed   = (r_state == ST_IDLE) ? seed_i : r_seed;
   assign w_pat_addr   = (r_state == ST_IDLE) ? 8'h00  : r_addr[7:0];
   assign w_unused_dat = ^rambus_wb_dat_i[31:8];

   rambus_bist_pattern u_pattern (
      .i_mode (w_pat_mode),
      .i_seed (w_pat_seed),
      .i_addr (w_pat_addr),
      .o_pat  (w_pat)
   );

   // The address advances on the ack edge, so during a gap r_addr already
   // holds the next address and w_pat is the next write data.
   always_ff @(posedge rambus_wb_clk_i) begin
      if (rambus_wb_rst_i) begin
         r_state     <= ST_IDLE;
         r_cyc       <= 1'b0;
         r_stb       <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_dat       <= '0;
         r_mode      <= '0;
         r_seed      <= '0;
         r_last      <= 1'b0;
         r_tmo       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_timeout   <= 1'b0;
         r_err_count <= '0;
         r_first_err <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_mode      <= mode_i;
                  r_seed      <= seed_i;
                  r_pass      <= 1'b0;
                  r_timeout   <= 1'b0;
                  r_err_count <= '0;
                  r_first_err <= '0;
                  r_addr      <= '0;
                  r_dat       <= w_pat;
                  r_last      <= 1'b0;
                  r_tmo       <= '0;
                  r_cyc       <= 1'b1;
                  r_stb       <= 1'b1;
                  r_we        <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= ST_WR;
               end
            end
            ST_WR, ST_RD: begin
               if (rambus_wb_ack_i) begin
                  r_cyc  <= 1'b0;
                  r_stb  <= 1'b0;
                  r_last <= (r_addr == LAST_ADDR);
                  r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
                  if (r_state == ST_RD && rambus_wb_dat_i[7:0] != w_pat) begin
                     r_err_count <= r_err_count + 1'b1;
                     if (r_err_count == '0)
                        r_first_err <= r_addr;
                  end
                  r_state <= (r_state == ST_WR) ? ST_WR_GAP : ST_RD_GAP;
               end else if (r_tmo == TMO_LAST) begin
                  r_cyc     <= 1'b0;
                  r_stb     <= 1'b0;
                  r_timeout <= 1'b1;
                  r_pass    <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= ST_ABORT;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            ST_WR_GAP: begin
               r_cyc <= 1'b1;
               r_stb <= 1'b1;
               r_tmo <= '0;
               r_dat <= w_pat;
               if (r_last) begin
                  r_we    <= 1'b0;
                  r_last  <= 1'b0;
                  r_state <= ST_RD;
               end else begin
                  r_state <= ST_WR;
               end
            end
            ST_RD_GAP: begin
               if (r_last) begin
                  r_pass  <= (r_err_count == '0);
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_cyc   <= 1'b1;
                  r_stb   <= 1'b1;
                  r_tmo   <= '0;
                  r_state <= ST_RD;
               end
            end
            ST_DONE, ST_ABORT: begin
               r_busy  <= 1'b0;
               r_we    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rambus_wb_cyc_o  = r_cyc;
   assign rambus_wb_stb_o  = r_stb;
   assign rambus_wb_we_o   = r_we;
   assign rambus_wb_sel_o  = RAMBUS_SEL_BYTE0;
   assign rambus_wb_addr_o = r_addr;
   assign rambus_wb_dat_o  = {24'h0, r_dat};
   assign busy_o           = r_busy;
   assign done_o           = r_done;
   assign pass_o           = r_pass;
   assign timeout_o        = r_timeout;
   assign err_count_o      = r_err_count;
   assign first_err_addr_o = r_first_err;

endmodule

// File: tb/tb_rambus_bist.sv
// tb_rambus_bist: drives rambus_bist against a behavioural SRAM responder and
// checks every bus cycle and the final status against a transfer-level model.
module tb_rambus_bist;

   localparam int DEPTH   = 512;
   localparam int ADDR_W  = 10;
   localparam int TIMEOUT = 255;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [1:0]        mode = '0;
   logic [7:0]        seed = '0;
   logic              cyc, stb, we;
   logic [3:0]        sel;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       dat_o;
   logic              ack = 1'b0;
   logic [31:0]       dat_i = '0;
   logic              busy, done, pass, tmo;
   logic [ADDR_W:0]   errc;
   logic [ADDR_W-1:0] ferr;

   int checks = 0;
   int failures = 0;
   int pe = 0;
   int c0 = 0;

   // responder controls
   logic [7:0] mem [DEPTH];
   int lat_max = 0;
   int wait_cnt = 0;
   int wr_acks = 0;
   int stall_at = -1;
   int flip_a = -1;
   int flip_b = -1;

   // model state
   bit         chk_en = 1'b0;
   bit         after_done = 1'b0;
   bit         expect_abort = 1'b0;
   logic [1:0] m_mode;
   logic [7:0] m_seed;
   int         t, m_err, m_first, stb_run, done_cnt, done_cyc;
   logic [7:0] cap [DEPTH];

   always #5 clk = ~clk;
   always @(posedge clk) pe <= pe + 1;

   rambus_bist #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .rambus_wb_clk_i  (clk),
      .rambus_wb_rst_i  (rst),
      .start_i          (start),
      .mode_i           (mode),
      .seed_i           (seed),
      .rambus_wb_cyc_o  (cyc),
      .rambus_wb_stb_o  (stb),
      .rambus_wb_we_o   (we),
      .rambus_wb_sel_o  (sel),
      .rambus_wb_addr_o (addr),
      .rambus_wb_dat_o  (dat_o),
      .rambus_wb_ack_i  (ack),
      .rambus_wb_dat_i  (dat_i),
      .busy_o           (busy),
      .done_o           (done),
      .pass_o           (pass),
      .timeout_o        (tmo),
      .err_count_o      (errc),
      .first_err_addr_o (ferr)
   );

   function automatic logic [7:0] pat(input logic [1:0] m, input logic [7:0] s, input int a);
      logic [7:0] a8;
      a8 = 8'(a % 256);
      case (m)
         2'd0:    return a8 ^ s;
         2'd1:    return ~(a8 ^ s);
         2'd2:    return (a % 2 == 1) ? 8'hAA : 8'h55;
         default: return s;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, pe - c0);
      end
   endtask

   // SRAM responder: ack after a (possibly random) wait, registered data.
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            ack <= 1'b0;
            wait_cnt = 0;
         end else if (ack) begin
            ack <= 1'b0;
            wait_cnt = (lat_max == 0) ? 0 : int'($urandom_range(lat_max, 0));
         end else if (cyc && stb) begin
            if (we && stall_at >= 0 && wr_acks == stall_at) begin
               wait_cnt = 0;
            end else if (wait_cnt > 0) begin
               wait_cnt--;
            end else begin
               ack <= 1'b1;
               if (we) begin
                  mem[addr[8:0]] <= dat_o[7:0];
                  wr_acks++;
               end else begin
                  dat_i <= {24'($urandom()),
                            mem[addr[8:0]] ^ ((int'(addr) == flip_a || int'(addr) == flip_b) ? 8'h01 : 8'h00)};
               end
            end
         end
      end
   end

   // Compare process: every cycle of a run, outputs against the transfer model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en && !rst && (pe - c0) >= 1) begin
            chk("sel", 32'(sel), 32'h1);
            chk("cyc_eq_stb", 32'(cyc), 32'(stb));
            chk("busy", 32'(busy), 32'(!after_done));
            chk("err_count_live", 32'(errc), 32'(m_err));
            if (m_err > 0) chk("first_err_live", 32'(ferr), 32'(m_first));
            if (stb) begin
               stb_run++;
               chk("stb_window", 32'(stb_run <= TIMEOUT), 32'h1);
               chk("xfer_in_range", 32'(t < 2 * DEPTH), 32'h1);
               if (t < 2 * DEPTH) begin
                  chk("we", 32'(we), 32'(t < DEPTH));
                  chk("addr", 32'(addr), 32'(t % DEPTH));
                  if (we) chk("wdat", dat_o, {24'h0, pat(m_mode, m_seed, t % DEPTH)});
               end
               if (ack) begin
                  if (we) cap[addr[8:0]] = dat_o[7:0];
                  else if (dat_i[7:0] != pat(m_mode, m_seed, t % DEPTH)) begin
                     if (m_err == 0) m_first = t % DEPTH;
                     m_err++;
                  end
                  t++;
                  stb_run = 0;
               end
            end
            if (done) begin
               done_cnt++;
               done_cyc = pe - c0;
               if (expect_abort) begin
                  chk("abort_wait", 32'(stb_run), TIMEOUT);
                  chk("abort_xfers", 32'(t), 32'(stall_at));
                  chk("abort_timeout", 32'(tmo), 32'h1);
                  chk("abort_pass", 32'(pass), 32'h0);
               end else begin
                  chk("end_xfers", 32'(t), 32'(2 * DEPTH));
                  chk("end_timeout", 32'(tmo), 32'h0);
                  chk("end_pass", 32'(pass), 32'(m_err == 0));
                  chk("end_err_count", 32'(errc), 32'(m_err));
                  chk("end_first_err", 32'(ferr), 32'(m_first));
               end
               after_done = 1'b1;
            end
         end
      end
   end

   task automatic run(input logic [1:0] md, input logic [7:0] sd, input int fa, input int fb,
                      input int lat, input int stall, input int poke_at, input int rst_at);
      @(negedge clk);
      m_mode = md; m_seed = sd;
      flip_a = fa; flip_b = fb; lat_max = lat; stall_at = stall; wr_acks = 0;
      t = 0; m_err = 0; m_first = 0; stb_run = 0; done_cnt = 0; done_cyc = -1;
      after_done = 1'b0; expect_abort = (stall >= 0);
      c0 = pe + 1;
      chk_en = 1'b1;
      @(negedge clk);
      mode = md; seed = sd; start = 1'b1;
      @(negedge clk);
      start = 1'b0; mode = 2'($urandom()); seed = 8'($urandom());
      for (int i = 0; i < 30000 && !after_done; i++) begin
         start = (poke_at > 0 && pe - c0 == poke_at);
         if (start) begin mode = ~md; seed = ~sd; end
         if (rst_at > 0 && pe - c0 == rst_at) begin
            chk_en = 1'b0;
            chk("pre_reset_err_count", 32'(errc), 32'h1);
            rst = 1'b1;
            @(negedge clk);
            chk("rst_cyc", 32'(cyc), 32'h0);
            chk("rst_stb", 32'(stb), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_done", 32'(done), 32'h0);
            chk("rst_err_count", 32'(errc), 32'h0);
            chk("rst_first_err", 32'(ferr), 32'h0);
            rst = 1'b0;
            return;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("run_completed", 32'(after_done), 32'h1);
      repeat (3) @(negedge clk);
      chk("done_pulses", 32'(done_cnt), 32'h1);
      chk("idle_after_done", 32'(busy), 32'h0);
      chk_en = 1'b0;
   endtask

   initial begin
      // watchdog
      #1500000;
      $display("FAIL watchdog: simulation did not finish, got hang expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_cyc", 32'(cyc), 32'h0);
      chk("reset_stb", 32'(stb), 32'h0);
      chk("reset_we", 32'(we), 32'h0);
      chk("reset_sel", 32'(sel), 32'h1);
      chk("reset_addr", 32'(addr), 32'h0);
      chk("reset_dat", dat_o, 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_pass", 32'(pass), 32'h0);
      chk("reset_timeout", 32'(tmo), 32'h0);
      chk("reset_err_count", 32'(errc), 32'h0);
      chk("reset_first_err", 32'(ferr), 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // clean run
      run(2'd0, 8'h00, -1, -1, 0, -1, 0, 0);
      chk("clean_done_cycle", 32'(done_cyc), 32'd3073);
      chk("clean_wdat5", 32'(cap[5]), 32'h05);
      chk("clean_pass", 32'(pass), 32'h1);
      chk("clean_err_count", 32'(errc), 32'h0);

      // fault injection
      run(2'd0, 8'h00, 17, 300, 0, -1, 0, 0);
      chk("fault_pass", 32'(pass), 32'h0);
      chk("fault_err_count", 32'(errc), 32'd2);
      chk("fault_first_err", 32'(ferr), 32'd17);

      // ack timeout at the 10th write
      run(2'd0, 8'h00, -1, -1, 0, 9, 0, 0);
      chk("tmo_done_cycle", 32'(done_cyc), 32'd283);
      chk("tmo_flag", 32'(tmo), 32'h1);
      chk("tmo_pass", 32'(pass), 32'h0);

      // modes 1..3
      run(2'd1, 8'hC3, -1, -1, 0, -1, 0, 0);
      chk("mode1_wdat1", 32'(cap[1]), 32'h3D);
      chk("mode1_pass", 32'(pass), 32'h1);
      run(2'd2, 8'hC3, -1, -1, 0, -1, 0, 0);
      chk("mode2_wdat1", 32'(cap[1]), 32'hAA);
      chk("mode2_pass", 32'(pass), 32'h1);
      run(2'd3, 8'hC3, -1, -1, 0, -1, 0, 0);
      chk("mode3_wdat1", 32'(cap[1]), 32'hC3);
      chk("mode3_pass", 32'(pass), 32'h1);

      // start while busy
      run(2'd0, 8'h3C, -1, -1, 0, -1, 100, 0);
      chk("busy_start_done_cycle", 32'(done_cyc), 32'd3073);
      chk("busy_start_pass", 32'(pass), 32'h1);

      // reset mid-read, then a normal run
      run(2'd0, 8'h00, 17, -1, 0, -1, 0, 2000);
      repeat (2) @(negedge clk);
      run(2'd1, 8'h5A, -1, -1, 0, -1, 0, 0);
      chk("post_reset_done_cycle", 32'(done_cyc), 32'd3073);
      chk("post_reset_pass", 32'(pass), 32'h1);

      // randomized runs: mode, seed, ack latency and fault addresses
      for (int r = 0; r < 3; r++) begin
         int fa, fb;
         fa = ($urandom_range(3, 0) == 0) ? -1 : int'($urandom_range(DEPTH - 1, 0));
         fb = ($urandom_range(1, 0) == 0) ? -1 : int'($urandom_range(DEPTH - 1, 0));
         run(2'($urandom()), 8'($urandom()), fa, fb, int'($urandom_range(3, 0)), -1, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
